// File: rtl/data_ram_resp.sv
// Data-side memory responder: word reads and byte-lane writes over a ce/ack
// handshake with a fixed number of wait states between request and acknowledge.
module data_ram_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    w_load;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [3:0]              r_sel;
    logic [31:0]             r_wdata;
    logic [31:0]             r_data_o;
    logic                    r_ack;
    logic                    r_busy;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_commit;
    logic                    w_req_we;
    logic [DEPTH_LOG2-1:0]   w_req_idx;
    logic [3:0]              w_req_sel;
    logic [31:0]             w_req_data;
    logic                    w_unused;

    assign w_unused = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    // Next-state, counter and request-capture decode.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ce) begin
                    w_load     = 1'b1;
                    w_cnt_next = WS;
                    w_next     = (WS != 4'd0) ? S_WAIT : S_ACK;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next = S_ACK;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the sampling edge, so the
    // live inputs stand in for the not-yet-loaded request registers.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_req_we   = we;
            w_req_idx  = addr[DEPTH_LOG2+1:2];
            w_req_sel  = sel;
            w_req_data = data_i;
        end else begin
            w_req_we   = r_we;
            w_req_idx  = r_idx;
            w_req_sel  = r_sel;
            w_req_data = r_wdata;
        end
    end

    assign w_commit = (w_next == S_ACK) && (r_state != S_ACK);

    // State, counter, request registers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_sel   <= 4'd0;
            r_wdata <= 32'h0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (w_next == S_ACK);
            r_busy  <= (w_next != S_IDLE);
            if (w_load) begin
                r_we    <= we;
                r_idx   <= addr[DEPTH_LOG2+1:2];
                r_sel   <= sel;
                r_wdata <= data_i;
            end
        end
    end

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_req_sel[i]) begin
                    r_mem[w_req_idx][8*i +: 8] <= w_req_data[8*i +: 8];
                end
            end
        end
    end

    // Read data register, loaded only by reads and held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_o <= 32'h0;
        end else if (w_commit && !w_req_we) begin
            r_data_o <= r_mem[w_req_idx];
        end
    end

    assign data_o = r_data_o;
    assign ack_o  = r_ack;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: three instances with 1, 0 and 3 wait states
// exercised through a shared clock and reset.
module tb_data_ram_resp;

    logic        clk;
    logic        rst;
    logic        ce     [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [3:0]  sel    [3];
    logic [31:0] data_i [3];
    logic [31:0] data_o [3];
    logic        ack_o  [3];
    logic        busy_o [3];

    int n_checks = 0;
    int n_errors = 0;

    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
        .data_i(data_i[0]), .data_o(data_o[0]), .ack_o(ack_o[0]), .busy_o(busy_o[0])
    );
    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
        .data_i(data_i[1]), .data_o(data_o[1]), .ack_o(ack_o[1]), .busy_o(busy_o[1])
    );
    data_ram_resp #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .ce(ce[2]), .we(we[2]), .addr(addr[2]), .sel(sel[2]),
        .data_i(data_i[2]), .data_o(data_o[2]), .ack_o(ack_o[2]), .busy_o(busy_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on instance k; returns read data and ack latency in cycles.
    task automatic do_req(input int k, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; data_i[k] = d;
        @(posedge clk);
        lat = -1;
        rd  = 32'h0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (ack_o[k]) begin
                lat = n;
                rd  = data_o[k];
                ce[k] = 1'b0;
            end
        end
        ce[k] = 1'b0;
        check_val("ack_seen", 32'(lat > 0), 32'd1);
        @(negedge clk);
        check_val("ack_width", 32'(ack_o[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        for (int k = 0; k < 3; k++) begin
            ce[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; sel[k] = 4'h0; data_i[k] = 32'h0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ack", 32'(ack_o[0]), 32'd0);
        check_val("rst_busy", 32'(busy_o[0]), 32'd0);
        check_val("rst_data", data_o[0], 32'h0);
        rst = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check_val("idle_ack", 32'(ack_o[k]), 32'd0);
                check_val("idle_busy", 32'(busy_o[k]), 32'd0);
                check_val("idle_data", data_o[k], 32'h0);
            end
        end

        // Full write/read with one wait state.
        do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
        check_val("wr_lat_ws1", 32'(lat), 32'd2);
        check_val("wr_keeps_data", rd, 32'h0);
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, lat);
        check_val("rd_lat_ws1", 32'(lat), 32'd2);
        check_val("rd_0x10", rd, 32'hDEADBEEF);

        // Byte lanes and the empty-select write.
        do_req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, lat);
        do_req(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, lat);
        do_req(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
        check_val("lanes_0101", rd, 32'h11BB33DD);
        do_req(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd, lat);
        check_val("sel0_lat", 32'(lat), 32'd2);
        check_val("sel0_data_held", rd, 32'h11BB33DD);
        do_req(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
        check_val("sel0_mem", rd, 32'h11BB33DD);

        // Aliasing above the array and ignored low address bits.
        do_req(0, 1'b1, 32'h0000_0004, 4'hF, 32'hCAFEF00D, rd, lat);
        do_req(0, 1'b0, 32'h0000_1007, 4'h0, 32'h0, rd, lat);
        check_val("alias_read", rd, 32'hCAFEF00D);

        // Zero wait states, ce held high: ack every other cycle.
        do_req(1, 1'b1, 32'h8, 4'hF, 32'h5A5A1234, rd, lat);
        check_val("wr_lat_ws0", 32'(lat), 32'd1);
        @(negedge clk);
        ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check_val($sformatf("b2b_ack_%0d", n), 32'(ack_o[1]), 32'(n % 2));
            check_val($sformatf("b2b_busy_%0d", n), 32'(busy_o[1]), 32'(n % 2));
            if (n % 2 == 1) check_val("b2b_data", data_o[1], 32'h5A5A1234);
        end
        ce[1] = 1'b0;

        // Reset in the middle of a three-wait-state write.
        do_req(2, 1'b1, 32'h40, 4'hF, 32'h0, rd, lat);
        check_val("wr_lat_ws3", 32'(lat), 32'd4);
        @(negedge clk);
        ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; sel[2] = 4'hF; data_i[2] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_busy", 32'(busy_o[2]), 32'd1);
        rst = 1'b0;
        ce[2] = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy_o[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check_val("abort_no_ack", 32'(ack_o[2]), 32'd0);
        end
        check_val("post_rst_data", data_o[0], 32'h0);
        do_req(2, 1'b0, 32'h40, 4'h0, 32'h0, rd, lat);
        check_val("abort_mem", rd, 32'h0);
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, lat);
        check_val("mem_survives_rst", rd, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
